alu_core: RTL and testbench
===========================

Name: alu_core

Overview:
Signed two's-complement arithmetic unit for each processor core in the multicore design. Takes the accumulator operand (a) and the bus operand (b), executes one of seven operations selected by a 3-bit opcode, and registers the result. The core's control unit drives the opcode; the accumulator datapath consumes the result and zero flag.

Parameters:
WIDTH, 12, operand and result width in bits (two's complement); legal range 2..32

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
a  input  WIDTH  signed operand A (accumulator side)
b  input  WIDTH  signed operand B (bus side)
selectOp  input  3  operation select
dataOut  output  WIDTH  signed registered result
zero  output  1  registered flag, 1 when dataOut is all zeros

Behaviour:
- Opcodes: 0 clr, 1 pass, 2 add, 3 sub, 4 mul, 5 inc, 6 idle, 7 reserved.
- clr: result = 0.
- pass: result = b.
- add: result = a + b.
- sub: result = a - b.
- mul: result = low WIDTH bits of the signed 2*WIDTH-bit product a*b.
- inc: result = a + 1.
- idle: result = current dataOut, so the register holds its value.
- reserved (7): same behaviour as idle.
- Result width: all results are truncated to WIDTH bits and wrap modulo 2^WIDTH.
- Overflow: no saturation and no overflow flag; e.g. 2047+1 gives -2048 at WIDTH=12.
- Operands are treated as signed throughout.
- Latency: combinational next-result from a, b and selectOp sampled at a rising clk edge. dataOut and zero update at that edge, one cycle latency. No handshake; a new op is accepted every cycle.
- zero is registered together with dataOut: zero = (next dataOut == 0). During idle it holds, consistent with the held dataOut.
- Reset: rst high asynchronously forces dataOut = 0 and zero = 1, independent of clk.
  - Reset held: outputs stay at 0/1.
  - Reset deassert: the first op is captured at the first rising clk edge with rst low.
  - Reset mid-operation: the in-flight result is discarded.
- X/unknown inputs are not handled specially.

Test Plan:
1. Reset: assert rst mid-cycle -> dataOut=0 and zero=1 immediately, without waiting for a clk edge. Release rst, then a=10, b=3, op clr -> dataOut=0, zero=1.
2. a=10, b=3, ops in sequence pass, add, sub, mul, inc, idle (one per cycle). Each result appears one edge after its op is sampled:
   - dataOut = 3, 13, 7, 30, 11, 11.
   - zero = 0 throughout.
3. a=20, b=-30, ops in sequence clr, pass, add, sub, mul, inc, idle:
   - dataOut = 0, -30, -10, 50, -600, 21, 21.
   - zero is 1 only after clr.
4. Wrap-around:
   - a=2047, b=1, add -> -2048.
   - a=-2048, b=1, sub -> 2047.
   - a=100, b=100, mul -> 1808 (10000 mod 4096).
   - a=-1, inc -> 0 with zero=1.
5. Reserved/idle hold: load 13 via add, then op 7 for three cycles while a and b change randomly -> dataOut stays 13. Then sub with a=b=5 -> 0, zero=1.
6. Random regression: 1000 cycles of random a, b, selectOp compared against a cycle-delayed reference model. Include rst pulses at random times.

Source files
------------

// File: rtl/alu_core.sv
// alu_core: signed two's-complement ALU with a registered result and zero flag.
// The next result is formed combinationally from a, b and selectOp and is
// captured on every rising clk edge; idle and reserved opcodes hold the result.
module alu_core #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       selectOp,
    output logic [WIDTH-1:0] dataOut,
    output logic             zero
);

    typedef enum logic [2:0] {
        OP_CLR  = 3'd0,
        OP_PASS = 3'd1,
        OP_ADD  = 3'd2,
        OP_SUB  = 3'd3,
        OP_MUL  = 3'd4,
        OP_INC  = 3'd5,
        OP_IDLE = 3'd6,
        OP_RSVD = 3'd7
    } op_e;

    op_e              op;
    logic [WIDTH-1:0] next_result;
    logic             next_zero;

    // All eight encodings are named, so the cast cannot produce an illegal state.
    assign op = op_e'(selectOp);

    // Select the next result; every arithmetic result wraps modulo 2^WIDTH.
    always_comb begin
        // NOTE: default assignment first so no path leaves next_result unassigned (no latch).
        next_result = dataOut;
        case (op)
            OP_CLR:  next_result = '0;
            OP_PASS: next_result = b;
            OP_ADD:  next_result = a + b;
            OP_SUB:  next_result = a - b;
            // The low WIDTH bits of a product do not depend on signedness, so a
            // WIDTH-bit multiply equals the low half of the signed 2*WIDTH product.
            OP_MUL:  next_result = a * b;
            OP_INC:  next_result = a + WIDTH'(1);
            default: next_result = dataOut;  // idle and reserved hold the result
        endcase
    end

    // Zero is derived from the value about to be registered, so it always
    // matches dataOut, including while idle holds it.
    assign next_zero = (next_result == '0);

    // Result and flag registers; reset clears the result and raises zero at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dataOut <= '0;
            zero    <= 1'b1;
        end else begin
            // NOTE: non-blocking so both registers update from pre-edge values together.
            dataOut <= next_result;
            zero    <= next_zero;
        end
    end

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: scoreboard bench for alu_core. The stimulus process computes each
// expected result with integer arithmetic and queues it; a monitor pops and
// compares one entry per rising edge while rst is low.
module tb_alu_core;

    localparam int WIDTH = 12;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       selectOp;
    logic [WIDTH-1:0] dataOut;
    logic             zero;

    typedef struct {
        int    data;
        bit    z;
        string tag;
    } exp_t;

    exp_t sb_q[$];
    int   model_acc;
    int   errors;
    int   checks;

    alu_core #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .selectOp (selectOp),
        .dataOut  (dataOut),
        .zero     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    // Reduce any integer into the signed range of a WIDTH-bit register.
    function automatic int wrap(input longint x);
        longint m;
        longint r;
        m = longint'(1) <<< WIDTH;
        r = x % m;
        if (r < 0) r += m;
        if (r >= m / 2) r -= m;
        return int'(r);
    endfunction

    // Behavioural reference: what the register holds after one edge.
    function automatic int ref_next(input int op, input int av, input int bv, input int acc);
        case (op)
            0:       return 0;
            1:       return wrap(longint'(bv));
            2:       return wrap(longint'(av) + longint'(bv));
            3:       return wrap(longint'(av) - longint'(bv));
            4:       return wrap(longint'(av) * longint'(bv));
            5:       return wrap(longint'(av) + 1);
            default: return acc;
        endcase
    endfunction

    function automatic int rand_operand();
        return int'($urandom_range(0, (1 << WIDTH) - 1)) - (1 << (WIDTH - 1));
    endfunction

    // Drive one operation at the falling edge and queue its expected result.
    // Directed calls may supply the expected value explicitly.
    task automatic issue(input int av, input int bv, input int op, input string tag,
                         input bit use_exp = 1'b0, input int exp_v = 0);
        int e;
        @(negedge clk);
        a        = WIDTH'(av);
        b        = WIDTH'(bv);
        selectOp = 3'(op);
        e = use_exp ? exp_v : ref_next(op, av, bv, model_acc);
        model_acc = e;
        sb_q.push_back('{data: e, z: (e == 0), tag: tag});
    endtask

    // Pulse rst mid-cycle. With in_flight set, an unqueued op is driven first
    // and must be discarded because rst covers the edge that would capture it.
    task automatic do_reset(input bit in_flight);
        @(negedge clk);
        if (in_flight) begin
            a        = WIDTH'(rand_operand());
            b        = WIDTH'(rand_operand());
            selectOp = 3'($urandom_range(0, 5));
        end
        #2 rst = 1'b1;
        #1;
        check("rst_async_data", int'($signed(dataOut)), 0);
        check("rst_async_zero", int'(zero), 1);
        @(posedge clk);
        #1;
        check("rst_held_data", int'($signed(dataOut)), 0);
        check("rst_held_zero", int'(zero), 1);
        #1 rst = 1'b0;
        model_acc = 0;
    endtask

    // Monitor: one result per rising edge with rst low.
    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && sb_q.size() > 0) begin
                x = sb_q.pop_front();
                check({x.tag, "_data"}, int'($signed(dataOut)), x.data);
                check({x.tag, "_zero"}, int'(zero), int'(x.z));
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        errors    = 0;
        checks    = 0;
        model_acc = 0;
        rst       = 1'b0;
        a         = '0;
        b         = '0;
        selectOp  = 3'd6;

        // Reset, then clr.
        do_reset(1'b0);
        issue(10, 3, 0, "clr0", 1'b1, 0);

        // a=10, b=3 sequence.
        issue(10, 3, 1, "pass_a", 1'b1, 3);
        issue(10, 3, 2, "add_a",  1'b1, 13);
        issue(10, 3, 3, "sub_a",  1'b1, 7);
        issue(10, 3, 4, "mul_a",  1'b1, 30);
        issue(10, 3, 5, "inc_a",  1'b1, 11);
        issue(10, 3, 6, "idle_a", 1'b1, 11);

        // a=20, b=-30 sequence.
        issue(20, -30, 0, "clr_b",  1'b1, 0);
        issue(20, -30, 1, "pass_b", 1'b1, -30);
        issue(20, -30, 2, "add_b",  1'b1, -10);
        issue(20, -30, 3, "sub_b",  1'b1, 50);
        issue(20, -30, 4, "mul_b",  1'b1, -600);
        issue(20, -30, 5, "inc_b",  1'b1, 21);
        issue(20, -30, 6, "idle_b", 1'b1, 21);

        // Wrap-around.
        issue(2047, 1, 2,    "add_wrap", 1'b1, -2048);
        issue(-2048, 1, 3,   "sub_wrap", 1'b1, 2047);
        issue(100, 100, 4,   "mul_wrap", 1'b1, 1808);
        issue(-1, 0, 5,      "inc_wrap", 1'b1, 0);

        // Reserved opcode holds while operands change.
        issue(10, 3, 2, "load13", 1'b1, 13);
        for (int i = 0; i < 3; i++)
            issue(rand_operand(), rand_operand(), 7, "rsvd_hold", 1'b1, 13);
        issue(5, 5, 3, "sub_zero", 1'b1, 0);

        // Reset discards an in-flight op; the first op after release is captured.
        issue(7, 9, 2, "pre_rst", 1'b1, 16);
        do_reset(1'b1);
        issue(-5, 4, 2, "post_rst", 1'b1, -1);

        // Random regression against the reference model, with reset pulses.
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 49) == 0)
                do_reset(1'($urandom_range(0, 1)));
            else
                issue(rand_operand(), rand_operand(), int'($urandom_range(0, 7)), "rnd");
        end

        @(negedge clk);
        @(negedge clk);
        check("queue_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
